sp_dma_addr_gen: RTL and testbench
==================================

# sp_dma_addr_gen

Generates the 9-bit SP memory doubleword address stream for an RSP DMA transfer. It walks a block of one or more rows, each of (len+1) doublewords, through IMEM/DMEM, with a req/gnt handshake to the memory port. Its registered address output feeds the 9-bit address pipeline register directly downstream. Busy and done go to the DMA controller.

## Interface
Parameters:
- ADDR_W, 9, SP memory doubleword address width (512 doublewords = 4 KB)
- ROW_W, 8, row-count width
- ROW_GAP, 1, idle cycles inserted between rows (0 or 1 only)

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  load addr_in/len_in/rows_in and begin; ignored while busy=1
- addr_in  in  ADDR_W  starting doubleword address
- len_in  in  ADDR_W  doublewords per row minus 1
- rows_in  in  ROW_W  row count minus 1
- gnt  in  1  memory accepted the current addr this cycle; only meaningful when req=1
- abort  in  1  terminate the transfer; no done pulse
- addr  out  ADDR_W  current doubleword address (registered)
- req  out  1  addr is valid and requested
- row_end  out  1  the current beat is the last beat of its row
- last  out  1  the current beat is the final beat of the transfer
- busy  out  1  a transfer is in progress (RUN, GAP or DONE)
- done  out  1  one-cycle pulse when the transfer completes normally

## Operation
- States: IDLE, RUN, GAP, DONE.
- IDLE:
  - start=1 → load addr←addr_in, len_cnt←len_in, len_rld←len_in, row_cnt←rows_in.
  - Next state is RUN.
- RUN: req=1.
  - No gnt: hold all state. addr must stay stable while req=1 and gnt=0.
  - gnt with len_cnt≠0: addr←addr+1 (mod 512), len_cnt−1.
  - gnt with len_cnt=0 and row_cnt≠0: addr+1, len_cnt←len_rld, row_cnt−1. Go to GAP if ROW_GAP=1, else stay in RUN.
  - gnt with len_cnt=0 and row_cnt=0: go to DONE. addr is not advanced.
- GAP: req=0 for one cycle, then RUN.
- DONE: done=1 and req=0 for one cycle, then IDLE.
- Combinational flags:
  - row_end = RUN & len_cnt==0
  - last = row_end & row_cnt==0
- Address arithmetic: ADDR_W-bit modulo add; 511+1 wraps to 0. Rows are contiguous in SP memory.
- abort=1 in any state → IDLE on the next edge; req, busy and done go low, addr holds.
  - abort together with gnt: the grant is consumed by memory, but abort wins. No further beats, no done.
- start together with abort while in IDLE: abort wins, start is ignored.
- Total beats = (len_in+1)·(rows_in+1). Max 512·256 beats; addr wraps as often as needed.

## Timing
- Reset values:
  - addr=0, req=0, row_end=0, last=0, busy=0, done=0
  - state=IDLE; len_cnt, len_rld, row_cnt all 0
- start sampled at edge N → req=1 with addr=addr_in from cycle N+1.
- Zero-wait memory (gnt tied high while req), single row: beats on cycles N+1…N+1+len_in. done on cycle N+2+len_in.
- Each row boundary with ROW_GAP=1 adds exactly one cycle with req=0.
- busy is high from N+1 through the done cycle inclusive.
- A new start is accepted in the cycle after done, i.e. once state=IDLE.
- reset asserted mid-transfer → outputs go to reset values immediately, without waiting for clk.

## Structure
- Shared package sp_dma_pkg:
  - state enum: IDLE, RUN, GAP, DONE
  - ADDR_W and ROW_W defaults
- Sub-module sp_dma_dcnt: loadable down-counter with zero flag, parameterised width.
  - Instantiated twice: len counter (ADDR_W bits) and row counter (ROW_W bits).
- Address incrementer and FSM live in the top level.

## Test plan
- Single row: addr_in=0x010, len_in=3, rows_in=0, gnt=1.
  - Expect addr 0x010..0x013 on 4 consecutive req cycles; last=1 on 0x013.
  - done one cycle later; busy for 5 cycles.
- Wrap: addr_in=0x1FE, len_in=3.
  - Expect addr sequence 0x1FE, 0x1FF, 0x000, 0x001.
- Multi-row: addr_in=0x100, len_in=1, rows_in=2, ROW_GAP=1.
  - Expect 0x100, 0x101, gap, 0x102, 0x103, gap, 0x104, 0x105, then done.
  - row_end=1 on 0x101, 0x103 and 0x105.
- Backpressure: gnt random ~50%.
  - addr and req stable across every non-gnt cycle.
  - Beat count exactly (len+1)(rows+1).
- Abort with gnt on beat 2 of a 6-beat transfer: IDLE next cycle, no done, busy=0.
- Async reset mid-RUN, plus start while busy:
  - reset: all outputs 0 immediately.
  - start while busy: no effect on the current sequence.

Source files
------------

// File: rtl/sp_dma_pkg.sv
// Shared types and width defaults for the SP DMA address generator.
package sp_dma_pkg;
    localparam int ADDR_W_DEF = 9;
    localparam int ROW_W_DEF  = 8;

    typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;
endpackage

// File: rtl/sp_dma_dcnt.sv
// Loadable down-counter with zero flag; load takes priority over decrement.
module sp_dma_dcnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec)
            cnt <= cnt - W'(1);
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/sp_dma_addr_gen.sv
// SP memory doubleword address stream for an RSP DMA block transfer
// (rows of len+1 contiguous doublewords, req/gnt handshake to the memory port).
module sp_dma_addr_gen
    import sp_dma_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int ROW_W   = ROW_W_DEF,
    parameter int ROW_GAP = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [ADDR_W-1:0] len_in,
    input  logic [ROW_W-1:0]  rows_in,
    input  logic              gnt,
    input  logic              abort,
    output logic [ADDR_W-1:0] addr,
    output logic              req,
    output logic              row_end,
    output logic              last,
    output logic              busy,
    output logic              done
);
    state_t            state;
    logic [ADDR_W-1:0] len_rld;
    logic [ADDR_W-1:0] len_cnt;
    logic [ROW_W-1:0]  row_cnt;
    logic              len_zero, row_zero;
    logic              start_go, beat;

    // abort gates every state change, including a start seen in IDLE
    assign start_go = (state == IDLE) & start & ~abort;
    assign beat     = (state == RUN) & gnt & ~abort;

    sp_dma_dcnt #(.W(ADDR_W)) u_len (
        .clk      (clk),
        .rst      (reset),
        .load     (start_go | (beat & len_zero & ~row_zero)),
        .load_val (start_go ? len_in : len_rld),
        .dec      (beat & ~len_zero),
        .cnt      (len_cnt),
        .zero     (len_zero)
    );

    sp_dma_dcnt #(.W(ROW_W)) u_row (
        .clk      (clk),
        .rst      (reset),
        .load     (start_go),
        .load_val (rows_in),
        .dec      (beat & len_zero & ~row_zero),
        .cnt      (row_cnt),
        .zero     (row_zero)
    );

    assign row_end = (state == RUN) & len_zero;
    assign last    = row_end & row_zero;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            addr    <= '0;
            len_rld <= '0;
            req     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else if (abort) begin
            state <= IDLE;
            req   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state   <= RUN;
                        addr    <= addr_in;
                        len_rld <= len_in;
                        req     <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                RUN: begin
                    if (gnt) begin
                        if (!len_zero) begin
                            addr <= addr + ADDR_W'(1);
                        end else if (!row_zero) begin
                            addr <= addr + ADDR_W'(1);
                            if (ROW_GAP != 0) begin
                                state <= GAP;
                                req   <= 1'b0;
                            end
                        end else begin
                            // final beat granted: addr stays on the last beat
                            state <= DONE;
                            req   <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    state <= RUN;
                    req   <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    req   <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sp_dma_addr_gen.sv
// Randomized bench for sp_dma_addr_gen against a beat-list reference model.
module tb_sp_dma_addr_gen;
    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [8:0] addr_in;
    logic [8:0] len_in;
    logic [7:0] rows_in;
    logic       gnt;
    logic       abort;
    logic [8:0] addr;
    logic       req, row_end, last, busy, done;

    int vecs = 0;
    int errs = 0;

    sp_dma_addr_gen #(.ADDR_W(9), .ROW_W(8), .ROW_GAP(1)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .addr_in (addr_in),
        .len_in  (len_in),
        .rows_in (rows_in),
        .gnt     (gnt),
        .abort   (abort),
        .addr    (addr),
        .req     (req),
        .row_end (row_end),
        .last    (last),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".req"},     32'(req),     0);
        chk({tag, ".busy"},    32'(busy),    0);
        chk({tag, ".done"},    32'(done),    0);
        chk({tag, ".row_end"}, 32'(row_end), 0);
        chk({tag, ".last"},    32'(last),    0);
    endtask

    // Model: beat k of a transfer addresses (a + k) mod 512; row k/(l+1) ends at
    // k%(l+1)==l; a gap cycle follows each non-final row end, done follows the last.
    task automatic run_xfer(input logic [8:0] a, input logic [8:0] l, input logic [7:0] r,
                            input int gpct, input bit junk_start);
        int  total;
        int  idx;
        int  grants;
        int  cyc;
        bit  exp_gap;
        bit  exp_done;
        bit  g;
        logic [8:0] ea;
        total    = (int'(l) + 1) * (int'(r) + 1);
        idx      = 0;
        grants   = 0;
        cyc      = 0;
        exp_gap  = 0;
        exp_done = 0;
        @(negedge clk);
        addr_in = a; len_in = l; rows_in = r; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < 4000) begin
            if (exp_done) begin
                chk("done.pulse", 32'(done), 1);
                chk("done.req",   32'(req),  0);
                chk("done.busy",  32'(busy), 1);
                gnt = 1'b0; start = 1'b0;
                break;
            end else if (exp_gap) begin
                chk("gap.req",  32'(req),  0);
                chk("gap.busy", 32'(busy), 1);
                exp_gap = 0;
                gnt = 1'b0;
            end else begin
                ea = 9'(int'(a) + idx);
                chk("beat.req",     32'(req),     1);
                chk("beat.addr",    32'(addr),    32'(ea));
                chk("beat.row_end", 32'(row_end), 32'((idx % (int'(l) + 1)) == int'(l)));
                chk("beat.last",    32'(last),    32'(idx == total - 1));
                chk("beat.busy",    32'(busy),    1);
                chk("beat.done",    32'(done),    0);
                g   = ($urandom_range(99) < gpct);
                gnt = g;
                if (g) begin
                    grants++;
                    if (idx == total - 1)
                        exp_done = 1;
                    else if ((idx % (int'(l) + 1)) == int'(l))
                        exp_gap = 1;
                    idx++;
                end
            end
            if (junk_start) begin
                start   = 1'($urandom_range(1));
                addr_in = 9'($urandom);
                len_in  = 9'($urandom);
                rows_in = 8'($urandom);
            end
            cyc++;
            @(negedge clk);
        end
        if (cyc >= 4000) chk("xfer.timeout", 1, 0);
        chk("xfer.beats", 32'(grants), 32'(total));
        @(negedge clk);
        chk("after.busy", 32'(busy), 0);
        chk("after.done", 32'(done), 0);
    endtask

    initial begin
        bit saw_done;
        reset = 1'b1; start = 1'b0; addr_in = '0; len_in = '0; rows_in = '0;
        gnt = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("rst.addr", 32'(addr), 0);
        chk_idle_outputs("rst");
        @(negedge clk);
        reset = 1'b0;

        run_xfer(9'h010, 9'd3, 8'd0, 100, 0);
        run_xfer(9'h1FE, 9'd3, 8'd0, 100, 0);
        run_xfer(9'h100, 9'd1, 8'd2, 100, 0);
        run_xfer(9'h1FF, 9'd0, 8'd0, 100, 0);
        run_xfer(9'h1FD, 9'd0, 8'd4, 100, 0);
        for (int t = 0; t < 8; t++)
            run_xfer(9'($urandom), 9'($urandom_range(7)), 8'($urandom_range(3)), 50, t[0]);

        // abort together with gnt on beat 2 of a 6-beat transfer
        @(negedge clk);
        addr_in = 9'h050; len_in = 9'd5; rows_in = 8'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("abort.beat0", 32'(addr), 32'h050);
        gnt = 1'b1;
        @(negedge clk);
        chk("abort.beat1", 32'(addr), 32'h051);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; gnt = 1'b0;
        chk("abort.addr_hold", 32'(addr), 32'h051);
        chk_idle_outputs("abort");
        saw_done = 0;
        repeat (8) begin
            @(negedge clk);
            if (done || req || busy) saw_done = 1;
        end
        chk("abort.quiet", 32'(saw_done), 0);

        // start with abort in IDLE: abort wins
        start = 1'b1; abort = 1'b1; addr_in = 9'h0C0;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("startabort.busy", 32'(busy), 0);
        chk("startabort.req",  32'(req),  0);

        // async reset mid-RUN
        addr_in = 9'h0AA; len_in = 9'd7; rows_in = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; gnt = 1'b1;
        @(negedge clk);
        chk("arst.pre_addr", 32'(addr), 32'h0AB);
        #2 reset = 1'b1;
        #1;
        chk("arst.addr", 32'(addr), 0);
        chk_idle_outputs("arst");
        @(negedge clk);
        gnt = 1'b0; reset = 1'b0;
        run_xfer(9'h033, 9'd2, 8'd1, 70, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
